// File: rtl/counter_pkg.sv
// Shared encodings for the counter family's direction and bound-handling controls.
package counter_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;
  localparam logic SAT_ON    = 1'b1;
  localparam logic SAT_WRAP  = 1'b0;

endpackage : counter_pkg

// File: rtl/udc_next_calc.sv
// Combinational next-count calculation for updown_counter_param: applies one step
// up or down in WIDTH+1 bits and resolves range overrun by wrapping or clamping.
module udc_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             mode_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic             bound_hit_o
);

  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_W  = MAX_W + (WIDTH+1)'(1);

  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] result;
  logic             out_of_range;

  assign count_w = {1'b0, count_i};
  assign sum_w   = count_w + STEP_W;

  // A step that leaves 0..MAX_VAL is the single bound event: it drives the
  // wrap/clamp choice and TC, and also covers holding at a saturated bound.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    result       = count_i;
    out_of_range = 1'b0;
    unique case (mode_i)
      MODE_UP: begin
        out_of_range = (sum_w > MAX_W);
        if (!out_of_range)        result = WIDTH'(sum_w);
        else if (sat_i == SAT_ON) result = WIDTH'(MAX_W);
        else                      result = WIDTH'(sum_w - MOD_W);
      end
      MODE_DOWN: begin
        out_of_range = (count_w < STEP_W);
        if (!out_of_range)        result = WIDTH'(count_w - STEP_W);
        else if (sat_i == SAT_ON) result = '0;
        else                      result = WIDTH'(count_w + MOD_W - STEP_W);
      end
      default: ;
    endcase
  end

  assign next_o      = result;
  assign wrap_o      = out_of_range && (sat_i == SAT_WRAP);
  assign bound_hit_o = out_of_range;

endmodule : udc_next_calc

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, wrap/saturate, a registered
// terminal-count pulse and a sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1,
  parameter int RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MODE,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             OVF
);

  if (WIDTH < 2) begin : g_chk_width
    $error("updown_counter_param: WIDTH must be at least 2");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > (longint'(1) << WIDTH) - 1) begin : g_chk_max
    $error("updown_counter_param: MAX_VAL must lie in 1..2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_chk_step
    $error("updown_counter_param: STEP must lie in 1..MAX_VAL");
  end
  if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_chk_rst
    $error("updown_counter_param: RST_VAL must lie in 0..MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap;
  logic             bound_hit;

  udc_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_next_calc (
    .count_i     (out_q),
    .mode_i      (MODE),
    .sat_i       (SAT),
    .next_o      (next_count),
    .wrap_o      (wrap),
    .bound_hit_o (bound_hit)
  );

  assign load_clamped = (LOAD_VAL > MAX_Q) ? MAX_Q : LOAD_VAL;

  // A wrap in the same cycle as CLR_OVF keeps OVF set.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q && !CLR_OVF;
    if (LOAD) begin
      out_d = load_clamped;
    end else if (EN) begin
      out_d = next_count;
      tc_d  = bound_hit;
      if (wrap) ovf_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_q <= RST_Q;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign OUT = out_q;
  assign TC  = tc_q;
  assign OVF = ovf_q;

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: two counter configurations against an integer reference model.
module tb_updown_counter_param;

  localparam int MAXV [2] = '{9, 200};
  localparam int STEPV[2] = '{1, 7};
  localparam int RSTV [2] = '{0, 3};

  logic       clk;
  logic       rst_n;
  logic       en   [2];
  logic       mode [2];
  logic       sat  [2];
  logic       load [2];
  logic       clr  [2];
  logic [7:0] lv   [2];

  logic [3:0] out_a;
  logic       tc_a, ovf_a;
  logic [7:0] out_b;
  logic       tc_b, ovf_b;

  int m_out[2];
  int m_tc [2];
  int m_ovf[2];
  int n_total = 0;
  int n_bad   = 0;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .RST_VAL(0)) dut_a (
    .CLK(clk), .RST(rst_n), .EN(en[0]), .MODE(mode[0]), .SAT(sat[0]),
    .LOAD(load[0]), .LOAD_VAL(lv[0][3:0]), .CLR_OVF(clr[0]),
    .OUT(out_a), .TC(tc_a), .OVF(ovf_a)
  );

  updown_counter_param #(.WIDTH(8), .MAX_VAL(200), .STEP(7), .RST_VAL(3)) dut_b (
    .CLK(clk), .RST(rst_n), .EN(en[1]), .MODE(mode[1]), .SAT(sat[1]),
    .LOAD(load[1]), .LOAD_VAL(lv[1]), .CLR_OVF(clr[1]),
    .OUT(out_b), .TC(tc_b), .OVF(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = RSTV[k];
      m_tc[k]  = 0;
      m_ovf[k] = 0;
    end
  endtask

  // One rising edge of the counter, from its rules in plain integer arithmetic.
  task automatic model_edge(input int k);
    int mx, t;
    bit wrapped;
    mx = MAXV[k];
    wrapped = 1'b0;
    if (load[k]) begin
      m_out[k] = (int'(lv[k]) > mx) ? mx : int'(lv[k]);
      m_tc[k]  = 0;
    end else if (en[k]) begin
      t = mode[k] ? m_out[k] + STEPV[k] : m_out[k] - STEPV[k];
      if (t < 0 || t > mx) begin
        m_tc[k] = 1;
        if (sat[k]) m_out[k] = mode[k] ? mx : 0;
        else begin
          m_out[k] = (t + mx + 1) % (mx + 1);
          wrapped  = 1'b1;
        end
      end else begin
        m_out[k] = t;
        m_tc[k]  = 0;
      end
    end else begin
      m_tc[k] = 0;
    end
    if (wrapped)     m_ovf[k] = 1;
    else if (clr[k]) m_ovf[k] = 0;
  endtask

  task automatic compare_all();
    check("a_out", int'(out_a), m_out[0]);
    check("a_tc",  int'(tc_a),  m_tc[0]);
    check("a_ovf", int'(ovf_a), m_ovf[0]);
    check("b_out", int'(out_b), m_out[1]);
    check("b_tc",  int'(tc_b),  m_tc[1]);
    check("b_ovf", int'(ovf_b), m_ovf[1]);
  endtask

  task automatic cycle();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 0; mode[k] = 0; sat[k] = 0; load[k] = 0; clr[k] = 0; lv[k] = '0;
    end
    model_reset();
    #23;
    compare_all();
    check("b_rst_val", int'(out_b), 3);
    #4 rst_n = 1'b1;

    // A: wrap counting up 0..9,0
    en[0] = 1; mode[0] = 1; sat[0] = 0;
    repeat (9) cycle();
    check("a_top", int'(out_a), 9);
    cycle();
    check("a_wrap_out", int'(out_a), 0);
    check("a_wrap_tc",  int'(tc_a), 1);
    check("a_wrap_ovf", int'(ovf_a), 1);

    // A: counting down wraps 0->9, then OVF clear and set-wins
    mode[0] = 0;
    cycle();
    check("a_dn_wrap_out", int'(out_a), 9);
    check("a_dn_wrap_tc",  int'(tc_a), 1);
    cycle();
    check("a_dn_tc_low", int'(tc_a), 0);
    en[0] = 0; clr[0] = 1;
    cycle();
    check("a_clr_ovf", int'(ovf_a), 0);
    clr[0] = 0; load[0] = 1; lv[0] = 8'd0;
    cycle();
    load[0] = 0; en[0] = 1; clr[0] = 1;
    cycle();
    check("a_set_wins_out", int'(out_a), 9);
    check("a_set_wins_ovf", int'(ovf_a), 1);
    clr[0] = 0; en[0] = 0;

    // B: saturating up from 190 with STEP=7
    load[1] = 1; lv[1] = 8'd190;
    cycle();
    check("b_load190", int'(out_b), 190);
    load[1] = 0; en[1] = 1; mode[1] = 1; sat[1] = 1;
    cycle();
    check("b_197", int'(out_b), 197);
    cycle();
    check("b_clamp_out", int'(out_b), 200);
    check("b_clamp_tc",  int'(tc_b), 1);
    cycle();
    check("b_hold_out", int'(out_b), 200);
    check("b_hold_tc",  int'(tc_b), 1);
    check("b_hold_ovf", int'(ovf_b), 0);

    // B: load clamps above MAX_VAL; load beats enable
    load[1] = 1; lv[1] = 8'd250;
    cycle();
    check("b_load_clamp", int'(out_b), 200);
    check("b_load_tc",    int'(tc_b), 0);
    lv[1] = 8'd100;
    cycle();
    check("b_load_wins", int'(out_b), 100);
    load[1] = 0; en[1] = 0;

    // B: wrap to set OVF, load 5, then asynchronous reset mid-cycle
    load[1] = 1; lv[1] = 8'd198;
    cycle();
    load[1] = 0; en[1] = 1; mode[1] = 1; sat[1] = 0;
    cycle();
    check("b_up_wrap_out", int'(out_b), 4);
    check("b_up_wrap_ovf", int'(ovf_b), 1);
    en[1] = 0; load[1] = 1; lv[1] = 8'd5;
    cycle();
    load[1] = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("b_async_rst", int'(out_b), 3);
    #3 rst_n = 1'b1;
    en[1] = 1; mode[1] = 1; sat[1] = 0;
    cycle();
    check("b_resume", int'(out_b), 10);

    // Disabled: MODE toggles, nothing moves
    en[0] = 0; en[1] = 0;
    for (int i = 0; i < 5; i++) begin
      mode[0] = ~mode[0];
      mode[1] = ~mode[1];
      cycle();
      check("b_en_off_out", int'(out_b), 10);
      check("b_en_off_tc",  int'(tc_b), 0);
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        en[k]   = ($urandom_range(0, 3) != 0);
        mode[k] = 1'($urandom);
        sat[k]  = 1'($urandom);
        load[k] = ($urandom_range(0, 15) == 0);
        clr[k]  = ($urandom_range(0, 7) == 0);
      end
      lv[0] = 8'($urandom_range(0, 15));
      lv[1] = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_updown_counter_param
